// File: rtl/melody_pkg.sv
// melody_pkg: pitch codes, frequency table, period helper, FSM states and ROM word layout
package melody_pkg;
  typedef enum logic [4:0] {
    REST, LOW_DO, LOW_RE, LOW_MI, LOW_FA, LOW_SO, LOW_LA, LOW_XI,
    MID_DO, MID_RE, MID_MI, MID_FA, MID_SO, MID_LA, MID_XI,
    HIGH_DO, HIGH_RE, HIGH_MI, HIGH_FA, HIGH_SO, HIGH_LA, HIGH_XI
  } pitch_t;
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, GAP} state_t;
  localparam int unsigned FREQ [7] = '{262, 294, 330, 349, 392, 440, 494};
  localparam int PITCH_LSB = 0;
  localparam int DUR_LSB = 5;
  // codes outside LOW_DO..HIGH_XI map to period 0, which the player treats as silence
  function automatic int unsigned pitch_period(int unsigned clk_hz, int unsigned code);
    if (code < int'(LOW_DO) || code > int'(HIGH_XI)) return 0;
    return clk_hz / (FREQ[(code - int'(LOW_DO)) % 7] << ((code - int'(LOW_DO)) / 7));
  endfunction
endpackage

// File: rtl/melody_player_if.sv
// melody_player_if: synchronous song ROM bus between player and board ROM
interface melody_player_if #(parameter int ADDR_W = 6);
  logic [ADDR_W-1:0] rom_addr;
  logic [8:0] rom_data;
  modport master(output rom_addr, input rom_data);
  modport slave(input rom_addr, output rom_data);
endinterface

// File: rtl/tone_gen.sv
// tone_gen: square-wave generator with programmable period and high time
module tone_gen #(
  parameter int P_W = 19
) (
  input  logic clk,
  input  logic rst,
  input  logic [P_W-1:0] period,
  input  logic [P_W-1:0] duty,
  input  logic enable,
  input  logic restart,
  output logic beep
);
  logic [P_W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      beep <= 1'b0;
    end else begin
      beep <= enable && (cnt < duty);
      cnt <= restart ? '0 : !enable ? cnt : (cnt == period - P_W'(1)) ? '0 : cnt + P_W'(1);
    end
  end
endmodule

// File: rtl/melody_player.sv
// melody_player: ROM-driven melody sequencer with loop, rests, gaps and duty select
module melody_player
  import melody_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int TICK_CYC = 25_000_000,
  parameter int GAP_CYC = 2_000_000,
  parameter int SONG_DEPTH = 64,
  parameter int ADDR_W = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic stop,
  input  logic loop_en,
  input  logic [1:0] duty_sel,
  melody_player_if.master rom,
  output logic beep,
  output logic music_sd,
  output logic busy,
  output logic done,
  output logic [ADDR_W-1:0] note_idx
);
  localparam int P_W = $clog2(CLK_HZ / FREQ[0] + 1);
  localparam int C_W = $clog2((TICK_CYC > GAP_CYC ? TICK_CYC : GAP_CYC) + 1);
  state_t state;
  logic [P_W-1:0] ptab [32];
  logic [P_W-1:0] period, duty;
  logic [C_W-1:0] cnt;
  logic [3:0] units, dur;
  logic [4:0] pitch;
  logic loop_q, tick_end, play_last, gap_last, song_end, again;
  for (genvar i = 0; i < 32; i++) begin : g_tab
    assign ptab[i] = P_W'(pitch_period(CLK_HZ, i));
  end
  assign dur = rom.rom_data[DUR_LSB +: 4];
  assign pitch = rom.rom_data[PITCH_LSB +: 5];
  assign tick_end = cnt == C_W'(TICK_CYC - 1);
  assign play_last = state == PLAY && tick_end && units == 4'd1;
  assign gap_last = state == GAP && cnt == C_W'(GAP_CYC - 1);
  // the last ROM slot ends the song exactly like an explicit marker
  assign song_end = (state == LOAD && dur == 4'd0) || (gap_last && rom.rom_addr == ADDR_W'(SONG_DEPTH - 1));
  assign again = state == LOAD ? loop_en : loop_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      period <= '0;
      duty <= '0;
      loop_q <= 1'b0;
    end else if (state == LOAD) begin
      period <= ptab[pitch];
      duty <= ptab[pitch] >> ({1'b0, duty_sel} + 3'd1);
      loop_q <= loop_en;
    end
  end
  always_ff @(posedge clk) begin
    done <= 1'b0;
    if (rst) begin
      state <= IDLE;
      rom.rom_addr <= '0;
      note_idx <= '0;
      busy <= 1'b0;
      music_sd <= 1'b0;
      cnt <= '0;
      units <= '0;
    end else if (stop) begin
      state <= IDLE;
      rom.rom_addr <= '0;
      busy <= 1'b0;
      music_sd <= 1'b0;
    end else if (song_end) begin
      if (again) begin
        state <= FETCH;
        rom.rom_addr <= '0;
      end else begin
        state <= IDLE;
        busy <= 1'b0;
        music_sd <= 1'b0;
        done <= 1'b1;
      end
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= FETCH;
          rom.rom_addr <= '0;
          busy <= 1'b1;
          music_sd <= 1'b1;
        end
        FETCH: state <= LOAD;
        LOAD: begin
          state <= PLAY;
          note_idx <= rom.rom_addr;
          units <= dur;
          cnt <= '0;
        end
        PLAY: begin
          cnt <= tick_end ? '0 : cnt + C_W'(1);
          units <= tick_end ? units - 4'd1 : units;
          state <= play_last ? GAP : PLAY;
        end
        GAP: if (gap_last) begin
          state <= FETCH;
          rom.rom_addr <= rom.rom_addr + ADDR_W'(1);
        end else begin
          cnt <= cnt + C_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
  // silence the final PLAY cycle so the gap starts with beep low
  tone_gen #(.P_W(P_W)) u_tone (
    .clk(clk),
    .rst(rst),
    .period(period),
    .duty(duty),
    .enable(state == PLAY && !play_last && !stop),
    .restart(state == LOAD),
    .beep(beep)
  );
endmodule
